// File: rtl/datapath.sv
// K&S multicycle datapath: PC, IR, 4x16 register file, ALU, flags and opcode decode.
// Define K_AND_S_UNDEF_HALT_EN to decode undefined opcodes as I_HALT instead of I_NOP.

package datapath_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;
endpackage

module datapath
    import datapath_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    logic [4:0]  pc;
    logic [4:0]  next_pc;
    logic [15:0] ir;
    logic [15:0] regs [4];

    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [16:0] sum17;
    logic [16:0] diff17;
    logic [15:0] alu_res;
    logic        alu_uov;
    logic        alu_sov;
    logic [1:0]  wr_dest;
    logic [15:0] wr_data;
    logic        unused_ir7;

    assign unused_ir7 = ir[7];

    always_comb begin
        case (ir[15:8])
            8'b0000_0000: decoded_instruction = I_NOP;
            8'b0000_0001: decoded_instruction = I_BRANCH;
            8'b0000_0010: decoded_instruction = I_BZERO;
            8'b0000_0011: decoded_instruction = I_BNEG;
            8'b1000_0001: decoded_instruction = I_LOAD;
            8'b1000_0010: decoded_instruction = I_STORE;
            8'b1001_0001: decoded_instruction = I_MOVE;
            8'b1010_0001: decoded_instruction = I_ADD;
            8'b1010_0010: decoded_instruction = I_SUB;
            8'b1010_0011: decoded_instruction = I_AND;
            8'b1010_0100: decoded_instruction = I_OR;
            8'b1111_1111: decoded_instruction = I_HALT;
`ifdef K_AND_S_UNDEF_HALT_EN
            default:      decoded_instruction = I_HALT;
`else
            default:      decoded_instruction = I_NOP;
`endif
        endcase
    end

    // MOVE reuses the ALU: with B tied to A, an OR passes the source through.
    assign a_val = regs[ir[5:4]];
    assign b_val = (decoded_instruction == I_MOVE) ? a_val : regs[ir[3:2]];

    assign sum17  = {1'b0, a_val} + {1'b0, b_val};
    assign diff17 = {1'b0, a_val} + {1'b0, ~b_val} + 17'd1;

    always_comb begin
        alu_res = 16'h0000;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            2'b00: alu_res = a_val | b_val;
            2'b01: begin
                alu_res = sum17[15:0];
                alu_uov = sum17[16];
                alu_sov = (a_val[15] == b_val[15]) && (sum17[15] != a_val[15]);
            end
            2'b10: begin
                // No carry out of A + ~B + 1 means a borrow occurred.
                alu_res = diff17[15:0];
                alu_uov = ~diff17[16];
                alu_sov = (a_val[15] != b_val[15]) && (diff17[15] != a_val[15]);
            end
            default: alu_res = a_val & b_val;
        endcase
    end

    assign wr_dest = (decoded_instruction == I_LOAD) ? ir[6:5] : ir[1:0];
    assign wr_data = c_sel ? alu_res : data_in;
    assign next_pc = branch ? ir[4:0] : pc + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= 5'd0;
            ir                <= 16'h0000;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            if (pc_enable) begin
                pc <= next_pc;
            end
            if (ir_enable) begin
                ir <= data_in;
            end
            if (write_reg_enable) begin
                regs[wr_dest] <= wr_data;
            end
            if (flags_reg_enable) begin
                zero_op           <= (alu_res == 16'h0000);
                neg_op            <= alu_res[15];
                unsigned_overflow <= alu_uov;
                signed_overflow   <= alu_sov;
            end
        end
    end

    assign ram_addr = addr_sel ? ir[4:0] : pc;
    assign data_out = regs[ir[6:5]];

endmodule
